uart_rx_drain: RTL and testbench



---
 rtl/uart_rx_drain.sv | 134 +++++++++++++
 tb/tb_uart_rx_drain.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drain.sv
// Receive drain for CoreUARTapb: reads bytes out of the UART with a one-cycle CSN/OEN strobe
// and queues them with their error tags in a show-ahead FIFO, keeping sticky status.
module uart_rx_drain #(
  parameter int FIFO_DEPTH  = 8,
  parameter bit DROP_ON_ERR = 1'b0,
  parameter int GUARD_CYC   = 6
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          uart_rxrdy,
  input  logic [7:0]                    uart_data,
  input  logic                          uart_parity_err,
  input  logic                          uart_framing_err,
  input  logic                          uart_overflow,
  output logic                          uart_csn,
  output logic                          uart_oen,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  output logic [1:0]                    m_err,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [7:0]                    err_cnt,
  output logic                          ovf_flag,
  input  logic                          clr_stat
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_LVL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      GUARD_LAST = 4'(GUARD_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          strobe_n_q, strobe_n_d;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic [7:0]    err_cnt_q;
  logic          ovf_q;

  logic          any_err;
  logic          push;
  logic          pop;
  logic          err_inc;

  // State register; the strobe is registered so CSN/OEN are glitch-free at the UART.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    if (RESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      strobe_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      strobe_n_q <= strobe_n_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (uart_rxrdy && (level_q < FULL_LVL)) state_d = ST_READ;
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: if (!uart_rxrdy || (wait_cnt_q == GUARD_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Guard counter starts at 0 in the first WAIT cycle.
  always_comb begin
    strobe_n_d = (state_d != ST_READ);
    wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
  end

  assign uart_csn = strobe_n_q;
  assign uart_oen = strobe_n_q;

  assign any_err = uart_parity_err | uart_framing_err;
  assign push    = (state_q == ST_READ) && !(DROP_ON_ERR && any_err);
  assign err_inc = (state_q == ST_READ) && any_err;
  assign m_valid = (level_q != '0);
  assign pop     = m_valid && m_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      // NOTE: storage is reset so the head reads 0 after reset; it is small enough to be flops.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {uart_framing_err, uart_parity_err, uart_data};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign m_data = mem_q[rd_ptr_q][7:0];
  assign m_err  = mem_q[rd_ptr_q][9:8];
  assign level  = level_q;

  // A new error in the same cycle as a clear restarts the count at 1; overflow beats clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_cnt_q <= 8'd0;
      ovf_q     <= 1'b0;
    end else begin
      if (err_inc) begin
        if (clr_stat)                err_cnt_q <= 8'd1;
        else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (clr_stat) begin
        err_cnt_q <= 8'd0;
      end
      if (uart_overflow)  ovf_q <= 1'b1;
      else if (clr_stat)  ovf_q <= 1'b0;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_uart_rx_drain.sv
// Bench for uart_rx_drain: directed timing cases plus a randomized UART/consumer run
// scored against a queue model of the byte stream and the status counters.
module tb_uart_rx_drain;

  localparam int DEPTH = 8;
  localparam int GUARD = 6;
  localparam int N_RND = 150;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       uart_rxrdy = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       pe = 1'b0, fe = 1'b0, ovf_in = 1'b0;
  logic       m_ready = 1'b0, clr_stat = 1'b0;
  logic       uart_csn, uart_oen, m_valid, ovf_flag;
  logic [7:0] m_data, err_cnt;
  logic [1:0] m_err;
  logic [3:0] level;

  logic       rxrdy1 = 1'b0, pe1 = 1'b0, fe1 = 1'b0, zero1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       csn1, oen1, m_valid1, ovf1;
  logic [7:0] m_data1, err_cnt1;
  logic [1:0] m_err1;
  logic [3:0] level1;

  uart_rx_drain #(.FIFO_DEPTH(DEPTH), .DROP_ON_ERR(1'b0), .GUARD_CYC(GUARD)) dut (
    .CLK(CLK), .RESET(RESET), .uart_rxrdy(uart_rxrdy), .uart_data(uart_data),
    .uart_parity_err(pe), .uart_framing_err(fe), .uart_overflow(ovf_in),
    .uart_csn(uart_csn), .uart_oen(uart_oen), .m_valid(m_valid), .m_data(m_data),
    .m_err(m_err), .m_ready(m_ready), .level(level), .err_cnt(err_cnt),
    .ovf_flag(ovf_flag), .clr_stat(clr_stat));

  uart_rx_drain #(.FIFO_DEPTH(DEPTH), .DROP_ON_ERR(1'b1), .GUARD_CYC(GUARD)) dut_drop (
    .CLK(CLK), .RESET(RESET), .uart_rxrdy(rxrdy1), .uart_data(data1),
    .uart_parity_err(pe1), .uart_framing_err(fe1), .uart_overflow(zero1),
    .uart_csn(csn1), .uart_oen(oen1), .m_valid(m_valid1), .m_data(m_data1),
    .m_err(m_err1), .m_ready(zero1), .level(level1), .err_cnt(err_cnt1),
    .ovf_flag(ovf1), .clr_stat(zero1));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present one byte on the selected UART, wait for its read strobe, then drop RXRDY.
  task automatic offer(input bit sel, input logic [7:0] d, input bit p, input bit f,
                       input int limit, input bit clr_at, output bit got, output int scyc);
    if (sel) begin data1 = d; pe1 = p; fe1 = f; rxrdy1 = 1'b1; end
    else     begin uart_data = d; pe = p; fe = f; uart_rxrdy = 1'b1; end
    got  = 1'b0;
    scyc = -1;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge CLK);
      if ((sel ? csn1 : uart_csn) == 1'b0) begin got = 1'b1; scyc = cyc; end
    end
    if (got) begin
      check("oen_with_csn", sel ? oen1 : uart_oen, 0);
      if (sel) rxrdy1 = 1'b0; else uart_rxrdy = 1'b0;
      clr_stat = clr_at;
      @(negedge CLK);
      clr_stat = 1'b0;
      check("csn_one_cycle", sel ? csn1 : uart_csn, 1);
      @(negedge CLK);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d, input logic [1:0] e);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"}, m_data, d);
    check({tag, "_err"}, m_err, e);
    m_ready = 1'b1;
    @(negedge CLK);
    m_ready = 1'b0;
  endtask

  bit         got;
  int         s1, s2, n_str;
  int         st[$];
  logic [9:0] exp_q[$];
  int         err_m;
  bit         ovf_m, offering, strobed, inc, clr_r, ovf_r, stuck;
  int         hold, gap, sent, wait_cyc, last_s;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_csn", uart_csn, 1);
    check("rst_oen", uart_oen, 1);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_err", m_err, 0);
    check("rst_level", level, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_ovf", ovf_flag, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // Single byte with exact latency
    uart_data = 8'h5A; uart_rxrdy = 1'b1;
    @(negedge CLK);
    check("t1_csn_low", uart_csn, 0);
    check("t1_oen_low", uart_oen, 0);
    check("t1_not_valid_yet", m_valid, 0);
    @(negedge CLK);
    check("t1_csn_high", uart_csn, 1);
    check("t1_valid", m_valid, 1);
    check("t1_data", m_data, 8'h5A);
    check("t1_err", m_err, 0);
    check("t1_level", level, 1);
    uart_rxrdy = 1'b0;
    n_str = 0;
    repeat (8) begin @(negedge CLK); if (!uart_csn) n_str++; end
    check("t1_no_extra_strobe", n_str, 0);
    pop_expect("t1_pop", 8'h5A, 2'b00);
    check("t1_empty_valid", m_valid, 0);
    check("t1_empty_level", level, 0);

    // Back-to-back bytes at minimum strobe spacing
    offer(0, 8'h21, 0, 0, 10, 0, got, s1);
    check("t2_got1", got, 1);
    offer(0, 8'h22, 0, 0, 10, 0, got, s2);
    check("t2_got2", got, 1);
    check("t2_spacing", s2 - s1, 3);
    pop_expect("t2_a", 8'h21, 2'b00);
    pop_expect("t2_b", 8'h22, 2'b00);

    // RXRDY stuck high: re-read only after the guard expires
    uart_data = 8'h11; uart_rxrdy = 1'b1; m_ready = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      if (!uart_csn) st.push_back(cyc);
      if (m_valid) check("t3_data", m_data, 8'h11);
    end
    check("t3_strobes", st.size() >= 4, 1);
    if (st.size() >= 4)
      for (int i = 1; i < 4; i++) check("t3_gap", st[i] - st[i-1], GUARD + 2);
    uart_rxrdy = 1'b0;
    repeat (10) @(negedge CLK);
    m_ready = 1'b0;
    check("t3_level", level, 0);

    // Full FIFO holds off the ninth read until a pop
    for (int b = 1; b <= 8; b++) begin
      offer(0, 8'(b), 0, 0, 10, 0, got, s1);
      check("t4_fill_got", got, 1);
    end
    check("t4_level_full", level, 8);
    offer(0, 8'h09, 0, 0, 20, 0, got, s1);
    check("t4_no_strobe_full", got, 0);
    check("t4_level_still_full", level, 8);
    pop_expect("t4_head", 8'h01, 2'b00);
    check("t4_level_after_pop", level, 7);
    check("t4_csn_after_pop", uart_csn, 1);
    offer(0, 8'h09, 0, 0, 3, 0, got, s1);
    check("t4_ninth_read", got, 1);
    check("t4_level_refull", level, 8);
    for (int b = 2; b <= 9; b++) pop_expect("t4_order", 8'(b), 2'b00);
    check("t4_drained", m_valid, 0);

    // Error tagging and dropping
    offer(0, 8'hA5, 1, 0, 10, 0, got, s1);
    check("t5_errcnt", err_cnt, 1);
    pop_expect("t5_tagged", 8'hA5, 2'b01);
    offer(1, 8'h3C, 0, 1, 10, 0, got, s1);
    check("t5_drop_got", got, 1);
    check("t5_drop_level", level1, 0);
    check("t5_drop_valid", m_valid1, 0);
    check("t5_drop_errcnt", err_cnt1, 1);
    offer(1, 8'h77, 0, 0, 10, 0, got, s1);
    check("t5_clean_valid", m_valid1, 1);
    check("t5_clean_data", m_data1, 8'h77);
    check("t5_clean_err", m_err1, 0);
    for (int i = 2; i <= 300; i++) begin
      offer(1, 8'($urandom), 1'(i % 2), 1'((i + 1) % 2), 10, 0, got, s1);
      if (i == 255) check("t5_errcnt_255", err_cnt1, 255);
    end
    check("t5_errcnt_sat", err_cnt1, 255);
    check("t5_drop_level_end", level1, 1);

    // Overflow flag and clear priorities
    ovf_in = 1'b1;
    @(negedge CLK);
    ovf_in = 1'b0;
    check("t6_ovf_set", ovf_flag, 1);
    clr_stat = 1'b1;
    @(negedge CLK);
    clr_stat = 1'b0;
    check("t6_ovf_clr", ovf_flag, 0);
    check("t6_errcnt_clr", err_cnt, 0);
    ovf_in = 1'b1; clr_stat = 1'b1;
    @(negedge CLK);
    ovf_in = 1'b0; clr_stat = 1'b0;
    check("t6_ovf_wins", ovf_flag, 1);
    clr_stat = 1'b1;
    @(negedge CLK);
    clr_stat = 1'b0;
    check("t6_ovf_clr2", ovf_flag, 0);
    offer(0, 8'h44, 1, 0, 10, 0, got, s1);
    check("t6_errcnt_one", err_cnt, 1);
    offer(0, 8'h45, 0, 1, 10, 1, got, s1);
    check("t6_inc_wins_clr", err_cnt, 1);
    pop_expect("t6_a", 8'h44, 2'b01);
    pop_expect("t6_b", 8'h45, 2'b10);

    // Reset while in WAIT with three bytes queued
    offer(0, 8'h81, 1, 0, 10, 0, got, s1);
    offer(0, 8'h82, 1, 0, 10, 0, got, s1);
    uart_data = 8'h83; pe = 1'b1; uart_rxrdy = 1'b1;
    @(negedge CLK);
    check("t7_read", uart_csn, 0);
    @(negedge CLK);
    check("t7_level3", level, 3);
    check("t7_errcnt3", err_cnt, 4);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; uart_rxrdy = 1'b0; pe = 1'b0;
    check("t7_level", level, 0);
    check("t7_valid", m_valid, 0);
    check("t7_csn", uart_csn, 1);
    check("t7_oen", uart_oen, 1);
    check("t7_errcnt", err_cnt, 0);
    check("t7_data", m_data, 0);
    @(negedge CLK);
    check("t7_idle", uart_csn, 1);

    // Randomized traffic against the queue model
    err_m = 0; ovf_m = 1'b0; offering = 1'b0; strobed = 1'b0; stuck = 1'b0;
    hold = 0; gap = 2; sent = 0; wait_cyc = 0; last_s = -100;
    for (int c = 0; c < 20000 && !stuck; c++) begin
      @(negedge CLK);
      check("rnd_level", level, exp_q.size());
      check("rnd_valid", m_valid, exp_q.size() != 0);
      check("rnd_errcnt", err_cnt, err_m);
      check("rnd_ovf", ovf_flag, ovf_m);
      if (sent == N_RND && !offering && exp_q.size() == 0) break;
      inc = 1'b0;
      if (!uart_csn) begin
        check("rnd_strobe_offered", offering && !strobed, 1);
        check("rnd_strobe_not_full", exp_q.size() < DEPTH, 1);
        check("rnd_strobe_spacing", (cyc - last_s) >= 3, 1);
        last_s  = cyc;
        strobed = 1'b1;
        hold    = $urandom_range(0, 3);
        exp_q.push_back({fe, pe, uart_data});
        inc = pe | fe;
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready && exp_q.size() != 0) begin
        check("rnd_head", {m_err, m_data}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      clr_r = ($urandom_range(0, 31) == 0);
      ovf_r = ($urandom_range(0, 39) == 0);
      clr_stat = clr_r;
      ovf_in   = ovf_r;
      if (inc)        err_m = clr_r ? 1 : ((err_m == 255) ? 255 : err_m + 1);
      else if (clr_r) err_m = 0;
      if (ovf_r)      ovf_m = 1'b1;
      else if (clr_r) ovf_m = 1'b0;
      if (offering) begin
        wait_cyc++;
        if (wait_cyc > 400) begin
          check("rnd_read_timeout", wait_cyc, 400);
          stuck = 1'b1;
        end
        if (strobed) begin
          if (hold == 0) begin
            uart_rxrdy = 1'b0; offering = 1'b0; strobed = 1'b0;
            gap = $urandom_range(1, 6);
          end else begin
            hold--;
          end
        end
      end else if (sent < N_RND) begin
        if (gap > 0) gap--;
        else begin
          uart_data = 8'($urandom);
          pe = ($urandom_range(0, 7) == 0);
          fe = ($urandom_range(0, 7) == 0);
          uart_rxrdy = 1'b1; offering = 1'b1; wait_cyc = 0; sent++;
        end
      end
    end
    @(negedge CLK);
    clr_stat = 1'b0; ovf_in = 1'b0; m_ready = 1'b0; uart_rxrdy = 1'b0;
    check("rnd_all_sent", sent, N_RND);
    check("rnd_all_drained", exp_q.size(), 0);
    check("rnd_final_level", level, 0);
    check("rnd_final_errcnt", err_cnt, err_m);
    check("rnd_final_ovf", ovf_flag, ovf_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at cycle %0d, expected end well before", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
